// File: rtl/can_reg_arb_pkg.sv
// Shared types for the CAN register write-port arbiter.
package can_reg_arb_pkg;

    typedef enum logic {
        H_IDLE,
        H_PEND
    } host_state_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_CORE_PEND,
        SRC_HOST_FORCE,
        SRC_CORE,
        SRC_HOST
    } grant_src_t;

endpackage

// File: rtl/can_reg_arb_decode.sv
// Register index to one-hot write-enable decode with range flag.
module can_reg_arb_decode #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3
) (
    input  logic [AW-1:0]    addr,
    output logic [NREGS-1:0] onehot,
    output logic             in_range
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            onehot[i] = (32'(addr) == i);
        end
        in_range = (32'(addr) < NREGS);
    end

endmodule

// File: rtl/can_reg_write_arbiter.sv
// Arbitrates the register-bank write port between the host interface and the
// CAN core, with reset-mode write protection and a host starvation limit.
module can_reg_write_arbiter
    import can_reg_arb_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      NREGS     = 8,
    parameter int unsigned      AW        = 3,
    parameter int unsigned      MAX_WAIT  = 3,
    parameter logic [NREGS-1:0] PROT_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_mode,
    input  logic             host_req,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_wdata,
    output logic             host_ack,
    output logic             host_err,
    input  logic             core_stb,
    input  logic [AW-1:0]    core_addr,
    input  logic [WIDTH-1:0] core_wdata,
    output logic [NREGS-1:0] reg_we,
    output logic [WIDTH-1:0] reg_wdata
);

    localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

    host_state_t      state_q, state_d;
    logic [AW-1:0]    hbuf_addr_q, hbuf_addr_d;
    logic [WIDTH-1:0] hbuf_data_q, hbuf_data_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             cp_valid_q, cp_valid_d;
    logic [NREGS-1:0] cp_we_q, cp_we_d;
    logic [WIDTH-1:0] cp_data_q, cp_data_d;
    logic [NREGS-1:0] reg_we_q, reg_we_d;
    logic [WIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic             host_ack_q, host_ack_d;
    logic             host_err_q, host_err_d;

    logic [AW-1:0]    host_sel_addr;
    logic [WIDTH-1:0] host_sel_data;
    logic [NREGS-1:0] h_onehot, c_onehot;
    logic             h_in_range, c_in_range;
    logic             h_capture, h_legal, h_cand, h_illegal, h_forced, c_valid;
    grant_src_t       grant;

    // While pending the buffered request is arbitrated; in idle the live bus is.
    assign host_sel_addr = (state_q == H_PEND) ? hbuf_addr_q : host_addr;
    assign host_sel_data = (state_q == H_PEND) ? hbuf_data_q : host_wdata;

    can_reg_arb_decode #(.NREGS(NREGS), .AW(AW)) u_host_dec (
        .addr     (host_sel_addr),
        .onehot   (h_onehot),
        .in_range (h_in_range)
    );

    can_reg_arb_decode #(.NREGS(NREGS), .AW(AW)) u_core_dec (
        .addr     (core_addr),
        .onehot   (c_onehot),
        .in_range (c_in_range)
    );

    // The ack cycle masks host_req so a still-held request is not re-captured.
    always_comb begin
        h_capture = (state_q == H_IDLE) && host_req && !host_ack_q;
        h_legal   = h_in_range && (((h_onehot & PROT_MASK) == '0) || reset_mode);
        h_cand    = (state_q == H_PEND) || (h_capture && h_legal);
        h_illegal = h_capture && !h_legal;
        c_valid   = core_stb && c_in_range;
        h_forced  = (state_q == H_PEND) && (wait_cnt_q == WCW'(MAX_WAIT)) && !cp_valid_q;

        if (cp_valid_q)    grant = SRC_CORE_PEND;
        else if (h_forced) grant = SRC_HOST_FORCE;
        else if (c_valid)  grant = SRC_CORE;
        else if (h_cand)   grant = SRC_HOST;
        else               grant = SRC_NONE;
    end

    always_comb begin
        state_d     = state_q;
        hbuf_addr_d = hbuf_addr_q;
        hbuf_data_d = hbuf_data_q;
        wait_cnt_d  = wait_cnt_q;
        cp_valid_d  = 1'b0;
        cp_we_d     = cp_we_q;
        cp_data_d   = cp_data_q;
        reg_we_d    = '0;
        reg_wdata_d = '0;
        host_ack_d  = 1'b0;
        host_err_d  = 1'b0;

        unique case (grant)
            SRC_CORE_PEND: begin
                reg_we_d    = cp_we_q;
                reg_wdata_d = cp_data_q;
            end
            SRC_HOST_FORCE, SRC_HOST: begin
                reg_we_d    = h_onehot;
                reg_wdata_d = host_sel_data;
                host_ack_d  = 1'b1;
            end
            SRC_CORE: begin
                reg_we_d    = c_onehot;
                reg_wdata_d = core_wdata;
            end
            default: ;
        endcase

        // A losing core strobe parks in the slot; a committing slot may reload.
        if (c_valid && (grant != SRC_CORE)) begin
            cp_valid_d = 1'b1;
            cp_we_d    = c_onehot;
            cp_data_d  = core_wdata;
        end

        if (h_capture) begin
            hbuf_addr_d = host_addr;
            hbuf_data_d = host_wdata;
        end

        if (h_illegal) begin
            host_ack_d = 1'b1;
            host_err_d = 1'b1;
            wait_cnt_d = '0;
        end else if ((grant == SRC_HOST) || (grant == SRC_HOST_FORCE)) begin
            state_d    = H_IDLE;
            wait_cnt_d = '0;
        end else if (h_cand) begin
            state_d = H_PEND;
            if (wait_cnt_q != WCW'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= H_IDLE;
            hbuf_addr_q <= '0;
            hbuf_data_q <= '0;
            wait_cnt_q  <= '0;
            cp_valid_q  <= 1'b0;
            cp_we_q     <= '0;
            cp_data_q   <= '0;
            reg_we_q    <= '0;
            reg_wdata_q <= '0;
            host_ack_q  <= 1'b0;
            host_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hbuf_addr_q <= hbuf_addr_d;
            hbuf_data_q <= hbuf_data_d;
            wait_cnt_q  <= wait_cnt_d;
            cp_valid_q  <= cp_valid_d;
            cp_we_q     <= cp_we_d;
            cp_data_q   <= cp_data_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            host_ack_q  <= host_ack_d;
            host_err_q  <= host_err_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_wdata = reg_wdata_q;
    assign host_ack  = host_ack_q;
    assign host_err  = host_err_q;

endmodule

// File: tb/tb_can_reg_write_arbiter.sv
// Bench for can_reg_write_arbiter: directed vectors, corner sequences and
// random traffic against a queue-based reference model.
module tb_can_reg_write_arbiter;

    localparam int unsigned MAXW = 3;

    logic       clk = 1'b0;
    logic       rst, reset_mode;
    logic       host_req, host_ack, host_err;
    logic [2:0] host_addr, core_addr;
    logic [7:0] host_wdata, core_wdata, reg_we, reg_wdata;
    logic       core_stb;

    logic       d6_req, d6_ack, d6_err, d6_cstb;
    logic [2:0] d6_addr, d6_caddr;
    logic [7:0] d6_wdata, d6_cdata, d6_rwdata;
    logic [5:0] d6_we;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    can_reg_write_arbiter #(
        .WIDTH(8), .NREGS(8), .AW(3), .MAX_WAIT(3), .PROT_MASK(8'h03)
    ) u_dut (
        .clk(clk), .rst(rst), .reset_mode(reset_mode),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_err(host_err),
        .core_stb(core_stb), .core_addr(core_addr), .core_wdata(core_wdata),
        .reg_we(reg_we), .reg_wdata(reg_wdata)
    );

    can_reg_write_arbiter #(
        .WIDTH(8), .NREGS(6), .AW(3), .MAX_WAIT(3), .PROT_MASK(6'h03)
    ) u_dut6 (
        .clk(clk), .rst(rst), .reset_mode(1'b1),
        .host_req(d6_req), .host_addr(d6_addr), .host_wdata(d6_wdata),
        .host_ack(d6_ack), .host_err(d6_err),
        .core_stb(d6_cstb), .core_addr(d6_caddr), .core_wdata(d6_cdata),
        .reg_we(d6_we), .reg_wdata(d6_rwdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model: writes are ordered by the priority rules, lost core
    // strobes wait in a FIFO, the host request remembers how often it lost.
    typedef struct { int unsigned idx; logic [7:0] d; } wr_t;
    wr_t         core_q[$];
    bit          m_hv, m_block;
    int unsigned m_ha, m_lost;
    logic [7:0]  m_hd;
    logic [7:0]  prot = 8'h03;
    logic [7:0]  e_we, e_wd;
    logic        e_ack, e_err;

    task automatic model_step();
        wr_t w;
        bit  host_now;
        e_we = '0; e_wd = '0; e_ack = 1'b0; e_err = 1'b0;
        if (!rst) begin
            core_q.delete();
            m_hv = 0; m_lost = 0; m_block = 0;
            return;
        end
        if (!m_hv && host_req && !m_block) begin
            if (32'(host_addr) >= 8 || (prot[host_addr] && !reset_mode)) begin
                e_ack = 1'b1; e_err = 1'b1;
            end else begin
                m_hv = 1; m_ha = 32'(host_addr); m_hd = host_wdata; m_lost = 0;
            end
        end
        host_now = 0;
        if (core_q.size() > 0) begin
            w = core_q.pop_front();
            e_we = 8'(1 << w.idx); e_wd = w.d;
            if (core_stb) core_q.push_back('{32'(core_addr), core_wdata});
        end else if (m_hv && m_lost >= MAXW) begin
            host_now = 1;
            if (core_stb) core_q.push_back('{32'(core_addr), core_wdata});
        end else if (core_stb) begin
            e_we = 8'(1 << core_addr); e_wd = core_wdata;
        end else if (m_hv) begin
            host_now = 1;
        end
        if (host_now) begin
            e_we = 8'(1 << m_ha); e_wd = m_hd; e_ack = 1'b1; m_hv = 0;
        end else if (m_hv && m_lost < MAXW) begin
            m_lost++;
        end
        m_block = e_ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic drive(input logic rm, input logic hr, input logic [2:0] ha, input logic [7:0] hd,
                         input logic cs, input logic [2:0] ca, input logic [7:0] cd);
        reset_mode = rm; host_req = hr; host_addr = ha; host_wdata = hd;
        core_stb = cs; core_addr = ca; core_wdata = cd;
    endtask

    task automatic chk_out(input string nm, input logic [7:0] we, input logic [7:0] wd,
                           input logic ack, input logic err);
        chk({nm, "_we"}, 32'(reg_we), 32'(we));
        if (we != '0) chk({nm, "_wdata"}, 32'(reg_wdata), 32'(wd));
        chk({nm, "_ack"}, 32'(host_ack), 32'(ack));
        chk({nm, "_err"}, 32'(host_err), 32'(err));
    endtask

    typedef struct {
        logic rm; logic hr; logic [2:0] ha; logic [7:0] hd;
        logic cs; logic [2:0] ca; logic [7:0] cd;
        logic [7:0] we; logic [7:0] wd; logic ack; logic err;
    } vec_t;

    vec_t        vt[15];
    logic [7:0]  sa_we[7];
    logic [7:0]  sa_wd[7];
    logic        sa_ack[7];
    bit          hactive;
    int unsigned ncyc;

    initial begin
        vt[0]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[1]  = '{1, 1, 3'd5, 8'hA5, 0, 3'd0, 8'h00, 8'h20, 8'hA5, 1, 0};
        vt[2]  = '{1, 1, 3'd5, 8'hA5, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[3]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[4]  = '{0, 1, 3'd1, 8'h5A, 0, 3'd0, 8'h00, 8'h00, 8'h00, 1, 1};
        vt[5]  = '{0, 1, 3'd1, 8'h5A, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[6]  = '{1, 1, 3'd1, 8'h5A, 0, 3'd0, 8'h00, 8'h02, 8'h5A, 1, 0};
        vt[7]  = '{1, 1, 3'd1, 8'h5A, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[8]  = '{1, 1, 3'd3, 8'h22, 1, 3'd2, 8'h11, 8'h04, 8'h11, 0, 0};
        vt[9]  = '{1, 1, 3'd3, 8'h22, 0, 3'd0, 8'h00, 8'h08, 8'h22, 1, 0};
        vt[10] = '{1, 1, 3'd3, 8'h22, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[11] = '{1, 1, 3'd7, 8'h77, 0, 3'd0, 8'h00, 8'h80, 8'h77, 1, 0};
        vt[12] = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[13] = '{0, 0, 3'd0, 8'h00, 1, 3'd0, 8'h33, 8'h01, 8'h33, 0, 0};
        vt[14] = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};

        sa_we  = '{8'h10, 8'h10, 8'h10, 8'h40, 8'h10, 8'h10, 8'h00};
        sa_wd  = '{8'hC0, 8'hC1, 8'hC2, 8'h66, 8'hC3, 8'hC4, 8'h00};
        sa_ack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        d6_req = 0; d6_addr = '0; d6_wdata = '0; d6_cstb = 0; d6_caddr = '0; d6_cdata = '0;
        rst = 1'b0;
        drive(1, 1, 3'd5, 8'hEE, 1, 3'd4, 8'hEE);
        tick();
        tick();
        chk_out("reset", 8'h00, 8'h00, 0, 0);
        chk("reset_wdata", 32'(reg_wdata), 32'h0);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].rm, vt[i].hr, vt[i].ha, vt[i].hd, vt[i].cs, vt[i].ca, vt[i].cd);
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].we, vt[i].wd, vt[i].ack, vt[i].err);
        end

        // Starvation: core streams to reg 4 while host waits on reg 6.
        for (int k = 0; k < 7; k++) begin
            drive(1, 1'(k < 5), 3'd6, 8'h66, 1'(k < 5), 3'd4, 8'(8'hC0 + k));
            tick();
            chk_out($sformatf("starve%0d", k), sa_we[k], sa_wd[k], sa_ack[k], 0);
        end

        // Reset while the host request is pending.
        drive(1, 1, 3'd5, 8'h55, 1, 3'd2, 8'h11);
        tick();
        chk_out("rstpend_core", 8'h04, 8'h11, 0, 0);
        rst = 1'b0;
        drive(1, 1, 3'd5, 8'h55, 0, 3'd0, 8'h00);
        tick();
        chk_out("rstpend_rst", 8'h00, 8'h00, 0, 0);
        chk("rstpend_rst_wdata", 32'(reg_wdata), 32'h0);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk_out("rstpend_drop", 8'h00, 8'h00, 0, 0);
        tick();
        chk_out("rstpend_drop2", 8'h00, 8'h00, 0, 0);
        drive(1, 1, 3'd3, 8'h3C, 0, 0, 0);
        tick();
        chk_out("rstpend_new", 8'h08, 8'h3C, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();

        // NREGS=6 build: out-of-range host and core addresses.
        d6_req = 1; d6_addr = 3'd6; d6_wdata = 8'h66;
        tick();
        chk("n6_host6_ack", 32'(d6_ack), 32'h1);
        chk("n6_host6_err", 32'(d6_err), 32'h1);
        chk("n6_host6_we", 32'(d6_we), 32'h0);
        d6_req = 0;
        d6_cstb = 1; d6_caddr = 3'd6; d6_cdata = 8'h99;
        tick();
        chk("n6_core6_we", 32'(d6_we), 32'h0);
        chk("n6_core6_ack", 32'(d6_ack), 32'h0);
        d6_caddr = 3'd5; d6_cdata = 8'h5F;
        tick();
        chk("n6_core5_we", 32'(d6_we), 32'h20);
        chk("n6_core5_wdata", 32'(d6_rwdata), 32'h5F);
        d6_cstb = 0;
        d6_req = 1; d6_addr = 3'd5; d6_wdata = 8'hB5;
        tick();
        chk("n6_host5_we", 32'(d6_we), 32'h20);
        chk("n6_host5_ack", 32'(d6_ack), 32'h1);
        chk("n6_host5_err", 32'(d6_err), 32'h0);
        d6_req = 0;

        // Random traffic against the model.
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        hactive = 0;
        ncyc = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hactive && ($urandom % 3 == 0)) begin
                hactive = 1;
                host_addr = 3'($urandom);
                host_wdata = 8'($urandom);
            end
            host_req = hactive;
            if ($urandom % 8 == 0) reset_mode = ~reset_mode;
            core_stb = ($urandom % 5) < 3;
            core_addr = 3'($urandom);
            core_wdata = 8'($urandom);
            rst = ($urandom % 200) != 0;
            tick();
            ncyc++;
            chk_out("rand", e_we, e_wd, e_ack, e_err);
            if (!rst) begin
                hactive = 0;
            end else if (host_ack) begin
                if ($urandom % 2 == 0) begin
                    host_addr = 3'($urandom);
                    host_wdata = 8'($urandom);
                end else begin
                    hactive = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
